// File: rtl/smc_ahb_wbuf.sv
// AHB-lite write-posting buffer in front of the static memory controller's AHB slave port.
// Define SMC_WBUF_ERR_CAPTURE_EN to enable the sticky posted-write error status (wbuf_err/wbuf_err_addr).
module smc_ahb_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic        hclk,
  input  logic        sys_reset,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic        m_hsel,
  output logic        m_hwrite,
  output logic        m_hready,
  output logic [31:0] m_haddr,
  output logic [1:0]  m_htrans,
  output logic [2:0]  m_hsize,
  output logic [31:0] m_hwdata,
  input  logic        smc_hready,
  input  logic [1:0]  smc_hresp,
  input  logic [31:0] smc_hrdata,
  output logic        wbuf_empty,
  output logic        wbuf_err,
  output logic [31:0] wbuf_err_addr,
  input  logic        err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [1:0] TR_IDLE    = 2'b00;
  localparam logic [1:0] TR_NONSEQ  = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA} state_e;

  state_e        state_q, state_d;
  logic          wrPend_q, wrPend_d;
  logic          rdPend_q, rdPend_d;
  logic [31:0]   reqAddr_q, reqAddr_d;
  logic [2:0]    reqSize_q, reqSize_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          empty_q, empty_d;
  logic          err_q, err_d;
  logic [31:0]   errAddr_q, errAddr_d;

  logic [31:0]   addrMem [DEPTH];
  logic [2:0]    sizeMem [DEPTH];
  logic [31:0]   dataMem [DEPTH];

  logic accept, push, pop, errHit;

  assign accept = hsel && hready && (htrans == 2'b10 || htrans == 2'b11);
  // The stall is released only by the registered count, so a same-cycle pop never lets a push through.
  assign push   = wrPend_q && (count_q != FULL_CNT);
  assign pop    = (state_q == W_DATA) && smc_hready;

`ifdef SMC_WBUF_ERR_CAPTURE_EN
  assign errHit = pop && (smc_hresp == RESP_ERROR);
`else
  assign errHit = 1'b0;
`endif

  always_comb begin
    wrPend_d  = wrPend_q;
    rdPend_d  = rdPend_q;
    reqAddr_d = reqAddr_q;
    reqSize_d = reqSize_q;
    if (hready) begin
      wrPend_d = accept && hwrite;
      rdPend_d = accept && !hwrite;
      if (accept) begin
        reqAddr_d = haddr;
        reqSize_d = hsize;
      end
    end
  end

  always_comb begin
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0 || push) state_d = W_ADDR;
        else if (rdPend_q)         state_d = R_ADDR;
      end
      W_ADDR: if (smc_hready) state_d = W_DATA;
      W_DATA: if (smc_hready) state_d = (count_d != '0) ? W_ADDR : IDLE;
      R_ADDR: if (smc_hready) state_d = R_DATA;
      R_DATA: if (smc_hready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign empty_d = (count_d == '0) && (state_d == IDLE);

  // A new error always wins over a simultaneous clear; the first captured address is otherwise kept.
  always_comb begin
    err_d     = err_q;
    errAddr_d = errAddr_q;
    if (errHit && (!err_q || err_clr)) begin
      err_d     = 1'b1;
      errAddr_d = addrMem[head_q];
    end else if (err_clr) begin
      err_d     = 1'b0;
      errAddr_d = '0;
    end
  end

  always_comb begin
    hready_out = 1'b1;
    hresp      = RESP_OKAY;
    hrdata     = '0;
    m_hsel     = 1'b0;
    m_hwrite   = 1'b0;
    m_htrans   = TR_IDLE;
    m_haddr    = '0;
    m_hsize    = '0;
    m_hwdata   = '0;
    if (wrPend_q && count_q == FULL_CNT) hready_out = 1'b0;
    if (rdPend_q) begin
      if (state_q == R_DATA) begin
        hready_out = smc_hready;
        hresp      = smc_hresp;
        hrdata     = smc_hrdata;
      end else begin
        hready_out = 1'b0;
      end
    end
    case (state_q)
      W_ADDR: begin
        m_hsel   = 1'b1;
        m_hwrite = 1'b1;
        m_htrans = TR_NONSEQ;
        m_haddr  = addrMem[head_q];
        m_hsize  = sizeMem[head_q];
      end
      W_DATA: m_hwdata = dataMem[head_q];
      R_ADDR: begin
        m_hsel   = 1'b1;
        m_htrans = TR_NONSEQ;
        m_haddr  = reqAddr_q;
        m_hsize  = reqSize_q;
      end
      default: ;
    endcase
  end

  assign m_hready      = smc_hready;
  assign wbuf_empty    = empty_q;
  assign wbuf_err      = err_q;
  assign wbuf_err_addr = errAddr_q;

  always_ff @(posedge hclk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= IDLE;
      wrPend_q  <= 1'b0;
      rdPend_q  <= 1'b0;
      reqAddr_q <= '0;
      reqSize_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      err_q     <= 1'b0;
      errAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      wrPend_q  <= wrPend_d;
      rdPend_q  <= rdPend_d;
      reqAddr_q <= reqAddr_d;
      reqSize_q <= reqSize_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
      errAddr_q <= errAddr_d;
    end
  end

  always_ff @(posedge hclk) begin
    if (push) begin
      addrMem[tail_q] <= reqAddr_q;
      sizeMem[tail_q] <= reqSize_q;
      dataMem[tail_q] <= hwdata;
    end
  end

endmodule

// File: tb/tb_smc_ahb_wbuf.sv
// Self-checking bench for smc_ahb_wbuf: a per-cycle vector table plus hand-written
// sequences for stalls, read-after-write ordering, error reporting and mid-operation reset.
module tb_smc_ahb_wbuf;

`ifdef SMC_WBUF_ERR_CAPTURE_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk;
  logic        sys_reset;
  logic        hsel, hwrite;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        m_hsel, m_hwrite, m_hready;
  logic [31:0] m_haddr;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic        smc_hready;
  logic [1:0]  smc_hresp;
  logic [31:0] smc_hrdata;
  logic        wbuf_empty, wbuf_err;
  logic [31:0] wbuf_err_addr;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic [31:0] addrLog[$];
  logic [31:0] dataLog[$];
  bit          wrPhase = 1'b0;

  smc_ahb_wbuf #(.DEPTH(4)) dut (
    .hclk(hclk), .sys_reset(sys_reset),
    .hsel(hsel), .hwrite(hwrite), .hready(hready_out),
    .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwdata(hwdata),
    .hready_out(hready_out), .hresp(hresp), .hrdata(hrdata),
    .m_hsel(m_hsel), .m_hwrite(m_hwrite), .m_hready(m_hready),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hsize(m_hsize), .m_hwdata(m_hwdata),
    .smc_hready(smc_hready), .smc_hresp(smc_hresp), .smc_hrdata(smc_hrdata),
    .wbuf_empty(wbuf_empty), .wbuf_err(wbuf_err), .wbuf_err_addr(wbuf_err_addr),
    .err_clr(err_clr)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Record downstream write order: accepted address phases and the data of the following completed data phase.
  always @(negedge hclk) begin
    if (sys_reset) begin
      wrPhase = 1'b0;
    end else begin
      if (wrPhase && smc_hready) begin
        dataLog.push_back(m_hwdata);
        wrPhase = 1'b0;
      end
      if (m_htrans == 2'b10 && m_hwrite && smc_hready) begin
        addrLog.push_back(m_haddr);
        wrPhase = 1'b1;
      end
    end
  end

  typedef struct {
    logic        hsel;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        smcReady;
    logic        expReady;
    logic [1:0]  expResp;
    logic [31:0] expRdata;
    logic [1:0]  expMtrans;
    logic [31:0] expMaddr;
    logic        expMwrite;
    logic [31:0] expMwdata;
    logic        expEmpty;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    hsel       = v.hsel;
    hwrite     = v.hwrite;
    htrans     = v.htrans;
    haddr      = v.haddr;
    hwdata     = v.hwdata;
    smc_hready = v.smcReady;
    smc_hresp  = 2'b00;
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idleBus();
    hsel   = 1'b0;
    hwrite = 1'b0;
    htrans = 2'b00;
    haddr  = 32'h0;
  endtask

  task automatic addrPhase(input logic wr, input logic [31:0] a);
    hsel   = 1'b1;
    hwrite = wr;
    htrans = 2'b10;
    haddr  = a;
  endtask

  initial begin
    int  waits;
    int  seen;
    int  notEmpty;
    bit  done;

    // Single write to 0x10 with a zero-wait SMC, followed by a read of 0x20 from an empty buffer.
    vecs[0] = '{1'b1, 1'b1, 2'b10, 32'h10, 32'h0,        1'b1, 1'b1, 2'b00, 32'h0,        2'b00, 32'h0,  1'b0, 32'h0,        1'b1};
    vecs[1] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'hA5A55A5A, 1'b1, 1'b1, 2'b00, 32'h0,        2'b00, 32'h0,  1'b0, 32'h0,        1'b1};
    vecs[2] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 1'b1, 2'b00, 32'h0,        2'b10, 32'h10, 1'b1, 32'h0,        1'b0};
    vecs[3] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 1'b1, 2'b00, 32'h0,        2'b00, 32'h0,  1'b0, 32'hA5A55A5A, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 1'b1, 2'b00, 32'h0,        2'b00, 32'h0,  1'b0, 32'h0,        1'b1};
    vecs[5] = '{1'b1, 1'b0, 2'b10, 32'h20, 32'h0,        1'b1, 1'b1, 2'b00, 32'h0,        2'b00, 32'h0,  1'b0, 32'h0,        1'b1};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 1'b0, 2'b00, 32'h0,        2'b00, 32'h0,  1'b0, 32'h0,        1'b1};
    vecs[7] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 1'b0, 2'b00, 32'h0,        2'b10, 32'h20, 1'b0, 32'h0,        1'b0};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 1'b1, 2'b00, 32'h12345678, 2'b00, 32'h0,  1'b0, 32'h0,        1'b0};
    vecs[9] = '{1'b0, 1'b0, 2'b00, 32'h0,  32'h0,        1'b1, 1'b1, 2'b00, 32'h0,        2'b00, 32'h0,  1'b0, 32'h0,        1'b1};

    sys_reset  = 1'b1;
    idleBus();
    hsize      = 3'b010;
    hwdata     = 32'h0;
    smc_hready = 1'b0;
    smc_hresp  = 2'b00;
    smc_hrdata = 32'h12345678;
    err_clr    = 1'b0;

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checkOutput("rst_hready_out", hready_out, 1);
    checkOutput("rst_hresp", hresp, 0);
    checkOutput("rst_hrdata", hrdata, 0);
    checkOutput("rst_m_htrans", m_htrans, 0);
    checkOutput("rst_m_hsel", m_hsel, 0);
    checkOutput("rst_m_hwrite", m_hwrite, 0);
    checkOutput("rst_m_haddr", m_haddr, 0);
    checkOutput("rst_m_hsize", m_hsize, 0);
    checkOutput("rst_m_hwdata", m_hwdata, 0);
    checkOutput("rst_m_hready_lo", m_hready, 0);
    checkOutput("rst_wbuf_empty", wbuf_empty, 1);
    checkOutput("rst_wbuf_err", wbuf_err, 0);
    checkOutput("rst_wbuf_err_addr", wbuf_err_addr, 0);
    smc_hready = 1'b1;
    #1;
    checkOutput("rst_m_hready_hi", m_hready, 1);
    tick();
    sys_reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      applyStimulus(vecs[i]);
      @(negedge hclk);
      checkOutput($sformatf("vec%0d_hready_out", i), hready_out, vecs[i].expReady);
      checkOutput($sformatf("vec%0d_hresp", i), hresp, vecs[i].expResp);
      checkOutput($sformatf("vec%0d_hrdata", i), hrdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_m_htrans", i), m_htrans, vecs[i].expMtrans);
      checkOutput($sformatf("vec%0d_m_haddr", i), m_haddr, vecs[i].expMaddr);
      checkOutput($sformatf("vec%0d_m_hwrite", i), m_hwrite, vecs[i].expMwrite);
      checkOutput($sformatf("vec%0d_m_hwdata", i), m_hwdata, vecs[i].expMwdata);
      checkOutput($sformatf("vec%0d_wbuf_empty", i), wbuf_empty, vecs[i].expEmpty);
    end

    // Five back-to-back writes against a stalled SMC: the fifth waits until the first entry pops.
    addrLog.delete();
    dataLog.delete();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) smc_hready = 1'b0;
      if (k < 5) addrPhase(1'b1, 32'(4 * k));
      else if (k == 5) idleBus();
      if (k >= 1 && k <= 5) hwdata = 32'h100 + 32'(k - 1);
      if (k == 7) smc_hready = 1'b1;
      @(negedge hclk);
      if (k >= 1 && k <= 4) checkOutput($sformatf("full_w%0d_zero_wait", k - 1), hready_out, 1);
      if (k >= 5 && k <= 8) checkOutput($sformatf("full_stall_c%0d", k), hready_out, 0);
      if (k == 8) checkOutput("full_first_wdata", m_hwdata, 32'h100);
      if (k == 9) checkOutput("full_release", hready_out, 1);
    end
    tick();
    hwdata = 32'h0;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge hclk);
      if (wbuf_empty && dataLog.size() >= 5) done = 1'b1;
    end
    checkOutput("full_drained", done, 1);
    checkOutput("full_addr_count", addrLog.size(), 5);
    checkOutput("full_data_count", dataLog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < addrLog.size()) checkOutput($sformatf("full_order_addr%0d", i), addrLog[i], 32'(4 * i));
      if (i < dataLog.size()) checkOutput($sformatf("full_order_data%0d", i), dataLog[i], 32'h100 + 32'(i));
    end

    // Three posted writes followed by a read: the read waits for every write to drain first.
    addrLog.delete();
    dataLog.delete();
    smc_hready = 1'b1;
    smc_hrdata = 32'hCAFE0004;
    tick(); addrPhase(1'b1, 32'h40);
    tick(); hwdata = 32'hD0; addrPhase(1'b1, 32'h44);
    tick(); hwdata = 32'hD1; addrPhase(1'b1, 32'h48);
    tick(); hwdata = 32'hD2; addrPhase(1'b0, 32'h4);
    tick(); hwdata = 32'h0;  idleBus();
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge hclk);
      if (m_htrans == 2'b10 && !m_hwrite) begin
        checkOutput("raw_writes_before_read", dataLog.size(), 3);
        checkOutput("raw_read_addr", m_haddr, 32'h4);
        checkOutput("raw_read_size", m_hsize, 3'b010);
      end
      if (hready_out) begin
        done = 1'b1;
        checkOutput("raw_hrdata", hrdata, 32'hCAFE0004);
      end else begin
        waits++;
        tick();
      end
    end
    checkOutput("raw_done", done, 1);
    checkOutput("raw_wait_cycles", waits, 6);

    // Posted writes that receive a two-cycle ERROR from the SMC.
    tick(); addrPhase(1'b1, 32'h100);
    tick(); idleBus(); hwdata = 32'h11;
    @(negedge hclk);
    checkOutput("perr_up_ready", hready_out, 1);
    checkOutput("perr_up_resp", hresp, 0);
    tick();
    @(negedge hclk);
    checkOutput("perr_m_htrans", m_htrans, 2'b10);
    checkOutput("perr_m_haddr", m_haddr, 32'h100);
    tick(); smc_hready = 1'b0; smc_hresp = 2'b01;
    @(negedge hclk);
    checkOutput("perr_not_yet", wbuf_err, 0);
    tick(); smc_hready = 1'b1; smc_hresp = 2'b01;
    tick(); smc_hresp = 2'b00; addrPhase(1'b1, 32'h104);
    @(negedge hclk);
    checkOutput("perr_flag", wbuf_err, 32'(ERR_EN));
    checkOutput("perr_addr", wbuf_err_addr, ERR_EN ? 32'h100 : 32'h0);
    tick(); idleBus(); hwdata = 32'h22;
    tick();
    tick(); smc_hready = 1'b0; smc_hresp = 2'b01;
    tick(); smc_hready = 1'b1; smc_hresp = 2'b01;
    tick(); smc_hresp = 2'b00; err_clr = 1'b1;
    @(negedge hclk);
    checkOutput("perr2_flag", wbuf_err, 32'(ERR_EN));
    checkOutput("perr2_addr_kept", wbuf_err_addr, ERR_EN ? 32'h100 : 32'h0);
    tick(); err_clr = 1'b0;
    @(negedge hclk);
    checkOutput("perr_clr_flag", wbuf_err, 0);
    checkOutput("perr_clr_addr", wbuf_err_addr, 0);

    // Read answered with the SMC's two-cycle ERROR response, passed through cycle for cycle.
    tick(); addrPhase(1'b0, 32'h200);
    tick(); idleBus();
    @(negedge hclk);
    checkOutput("rerr_wait", hready_out, 0);
    tick();
    @(negedge hclk);
    checkOutput("rerr_m_htrans", m_htrans, 2'b10);
    checkOutput("rerr_m_haddr", m_haddr, 32'h200);
    tick(); smc_hready = 1'b0; smc_hresp = 2'b01;
    @(negedge hclk);
    checkOutput("rerr_c1_ready", hready_out, 0);
    checkOutput("rerr_c1_resp", hresp, 2'b01);
    tick(); smc_hready = 1'b1; smc_hresp = 2'b01;
    @(negedge hclk);
    checkOutput("rerr_c2_ready", hready_out, 1);
    checkOutput("rerr_c2_resp", hresp, 2'b01);
    tick(); smc_hresp = 2'b00;
    @(negedge hclk);
    checkOutput("rerr_after_ready", hready_out, 1);
    checkOutput("rerr_after_resp", hresp, 0);

    // Reset pulsed with two entries queued and the downstream master in its write data phase.
    smc_hready = 1'b0;
    tick(); addrPhase(1'b1, 32'h300);
    tick(); hwdata = 32'h33; addrPhase(1'b1, 32'h304);
    tick(); hwdata = 32'h34; idleBus(); smc_hready = 1'b1;
    tick(); smc_hready = 1'b0;
    @(negedge hclk);
    checkOutput("mrst_pre_wdata", m_hwdata, 32'h33);
    tick(); sys_reset = 1'b1;
    #1;
    checkOutput("mrst_m_htrans", m_htrans, 0);
    checkOutput("mrst_m_hsel", m_hsel, 0);
    checkOutput("mrst_m_hwdata", m_hwdata, 0);
    checkOutput("mrst_hready_out", hready_out, 1);
    checkOutput("mrst_wbuf_empty", wbuf_empty, 1);
    tick(); sys_reset = 1'b0; smc_hready = 1'b1; hwdata = 32'h0;
    seen = 0;
    notEmpty = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge hclk);
      if (m_htrans != 2'b00) seen++;
      if (!wbuf_empty) notEmpty++;
    end
    checkOutput("mrst_no_transfer", seen, 0);
    checkOutput("mrst_stays_empty", notEmpty, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/smc_ahb_wbuf.md
# smc_ahb_wbuf

AHB-lite write-posting buffer between the system AHB bus and the static memory controller's AHB slave port. Writes complete upstream with zero wait states while a DEPTH-entry FIFO has room, then drain to the SMC one non-pipelined transfer at a time. Reads are held until all posted writes have drained, then forwarded to the SMC, so read-after-write ordering is preserved. Errors returned by the SMC on posted writes are reported as a sticky status.

## Interface
- DEPTH, 4, number of posted-write entries; power of two, 2..16
- hclk  in  1  AHB system clock; every register is on its rising edge
- sys_reset  in  1  asynchronous, active-high reset
- hsel, hwrite, hready  in  1 each  upstream AHB-lite select, direction and global ready
- haddr  in  32  upstream address
- htrans  in  2  upstream transfer type
- hsize  in  3  upstream transfer size
- hwdata  in  32  upstream write data
- hready_out  out  1  upstream ready
- hresp  out  2  upstream response
- hrdata  out  32  upstream read data
- m_hsel, m_hwrite, m_hready  out  1 each  to the SMC's hsel, hwrite and hready inputs
- m_haddr  out  32  to the SMC's haddr input
- m_htrans  out  2  to the SMC's htrans input
- m_hsize  out  3  to the SMC's hsize input
- m_hwdata  out  32  to the SMC's hwdata input
- smc_hready  in  1  SMC ready
- smc_hresp  in  2  SMC response
- smc_hrdata  in  32  SMC read data
- wbuf_empty  out  1  high when the FIFO is empty and the downstream master is idle
- wbuf_err  out  1  sticky flag: a posted write received an ERROR response
- wbuf_err_addr  out  32  address of the first failing posted write
- err_clr  in  1  clears wbuf_err and wbuf_err_addr

## Operation
- **Upstream accept:** a transfer is accepted when hsel & htrans[1] & hready; haddr, hsize and hwrite are registered.
- **Write data phase:**
  - If count != DEPTH: push {addr, size, hwdata}, hready_out=1, hresp=OKAY.
  - Otherwise: hready_out=0 and hold until count != DEPTH, then push.
  - A pop in the same cycle as the stall does not release it.
- **Read data phase:**
  - hready_out=0 until the FIFO is empty and the downstream master is IDLE; then the master issues the read.
  - hrdata = smc_hrdata, hready_out = smc_hready and hresp = smc_hresp, passed through combinationally while in R_DATA. This carries the SMC's two-cycle ERROR response unchanged.
- **No transfer:** IDLE/BUSY, unselected, or no transfer pending → hready_out=1, hresp=OKAY.
- **Downstream master FSM, states IDLE, W_ADDR, W_DATA, R_ADDR, R_DATA:**
  - IDLE → W_ADDR when the FIFO is not empty. Writes always have priority.
  - IDLE → R_ADDR when a read is pending and the FIFO is empty.
  - W_ADDR / R_ADDR: m_htrans=NONSEQ, m_hsel=1, m_haddr/m_hsize from the FIFO head or the read register. Advance to the data state when smc_hready=1.
  - W_DATA: m_hwdata = head data. When smc_hready=1: pop, then go to W_ADDR if more entries remain, else IDLE.
  - R_DATA: when smc_hready=1, go to IDLE.
  - Outside the address states: m_htrans=IDLE and m_hsel=0.
  - m_hready = smc_hready at all times.
- **Posted-write error:** if smc_hresp=ERROR on the final cycle of W_DATA, the entry is still popped. If wbuf_err=0: set wbuf_err and capture its address. Later errors do not overwrite the captured address.
- **err_clr:** clears wbuf_err and wbuf_err_addr; a simultaneous new error wins.
- **FIFO:** head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- **Reset, including mid-operation:** FIFO emptied, FSM to IDLE, any pending read dropped, wbuf_err cleared.

## Timing
- **Reset values:** hready_out=1, hresp=OKAY, hrdata=0, m_htrans=IDLE, m_hsel=0, m_hwrite=0, m_haddr=0, m_hsize=0, m_hwdata=0, m_hready=smc_hready, wbuf_empty=1, wbuf_err=0, wbuf_err_addr=0.
- **Posted write:** 0 upstream wait states when not full; entry visible at the FIFO head the cycle after the data phase.
- **Downstream write:** minimum 2 cycles per entry (address + data), plus SMC wait states.
- **Downstream read:** issued no earlier than the cycle after the last write pops; minimum upstream read latency with an empty FIFO is 2 wait cycles plus SMC wait states.
- **wbuf_empty:** registered; goes high the cycle after the last W_DATA completes.

## Configuration
- SMC_WBUF_ERR_CAPTURE_EN defined: wbuf_err / wbuf_err_addr behave as described above.
- Not defined: both outputs are tied to 0, err_clr is ignored, and posted-write errors are silently dropped; the read error path is unaffected.

## Test plan
- Single write 0x0000_0010=0xA5A5_5A5A, SMC zero-wait → upstream hready_out=1 in the data phase; m_htrans=NONSEQ 1 cycle later; m_hwdata=0xA5A5_5A5A; wbuf_empty=1 two cycles after that.
- DEPTH=4, SMC smc_hready=0 held, 5 back-to-back writes → first four 0-wait; fifth stalls with hready_out=0 until the first pop, then completes; downstream order matches addresses 0x0,0x4,0x8,0xC,0x10.
- Three posted writes then read of 0x4 → read stalls until the third write pops; hrdata = the value the SMC returns; read address on m_haddr only after the final W_DATA.
- Posted write to 0x100 gets ERROR → upstream saw OKAY; wbuf_err=1, wbuf_err_addr=0x100; a second error at 0x104 leaves the address at 0x100; err_clr → both 0.
- Read with SMC two-cycle ERROR → hresp=ERROR with hready_out=0 then 1, matching smc_hresp/smc_hready cycle for cycle.
- sys_reset pulsed with 2 entries queued and the FSM in W_DATA → outputs immediately at reset values; after release no downstream transfer is issued.
